// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry test-counter checker.
package telemetry_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/telemetry_test_checker_sat_counter.sv
// Saturating event counter: holds at all-ones, synchronous clear beats increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/telemetry_test_checker.sv
// Requests one telemetry word per trigger and checks the words form a wrap-around
// counter sequence, accumulating rx / error / timeout / overrun statistics.
module telemetry_test_checker
    import telemetry_pkg::*;
#(
    parameter int CNT_W          = 10,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int STAT_W         = 32
) (
    input  logic              clk_128MHz,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear_stats,
    input  logic              telemetry_trigger,
    output logic              telemetry_request,
    input  logic [DATA_W-1:0] telemetry_data,
    input  logic              telemetry_data_valid,
    output logic              locked,
    output logic [CNT_W-1:0]  last_data,
    output logic [STAT_W-1:0] rx_count,
    output logic [STAT_W-1:0] error_count,
    output logic [STAT_W-1:0] timeout_count,
    output logic [STAT_W-1:0] overrun_count
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic              req_q;
    logic [TMR_W-1:0]  timer_q;
    logic              locked_q;
    logic [CNT_W-1:0]  last_q;
    logic [CNT_W-1:0]  expected_q;

    logic              accept;
    logic              timeout;
    logic              overrun;
    logic              seq_err;
    logic [CNT_W-1:0]  cnt_rx;
    logic              upper_set;

    assign cnt_rx    = telemetry_data[CNT_W-1:0];
    assign upper_set = |telemetry_data[DATA_W-1:CNT_W];
    assign accept    = (state_q == WAIT) && telemetry_data_valid;
    assign timeout   = (state_q == WAIT) && !telemetry_data_valid && (timer_q == TMR_LAST);
    assign overrun   = telemetry_trigger && (state_q != IDLE);
    // The first word after lock-loss only establishes the sequence, so it is never compared.
    assign seq_err   = accept && locked_q && ((cnt_rx != expected_q) || upper_set);

    always_ff @(posedge clk_128MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_q <= 1'b0;
                    if (telemetry_trigger && enable) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                    req_q   <= 1'b0;
                    timer_q <= '0;
                end
                WAIT: begin
                    req_q <= 1'b0;
                    if (telemetry_data_valid || (timer_q == TMR_LAST)) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Expected value always resyncs to the received word, so one dropped word costs one error.
    always_ff @(posedge clk_128MHz or negedge rst_n) begin
        if (!rst_n) begin
            locked_q   <= 1'b0;
            last_q     <= '0;
            expected_q <= '0;
        end else if (clear_stats) begin
            locked_q   <= 1'b0;
            last_q     <= '0;
            expected_q <= '0;
        end else if (accept) begin
            locked_q   <= 1'b1;
            last_q     <= cnt_rx;
            expected_q <= cnt_rx + CNT_W'(1);
        end
    end

    sat_counter #(.W(STAT_W)) u_rx_cnt (
        .clk_i   (clk_128MHz),
        .rst_n_i (rst_n),
        .clr_i   (clear_stats),
        .inc_i   (accept),
        .count_o (rx_count)
    );

    sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk_i   (clk_128MHz),
        .rst_n_i (rst_n),
        .clr_i   (clear_stats),
        .inc_i   (seq_err),
        .count_o (error_count)
    );

    sat_counter #(.W(STAT_W)) u_to_cnt (
        .clk_i   (clk_128MHz),
        .rst_n_i (rst_n),
        .clr_i   (clear_stats),
        .inc_i   (timeout),
        .count_o (timeout_count)
    );

    sat_counter #(.W(STAT_W)) u_ovr_cnt (
        .clk_i   (clk_128MHz),
        .rst_n_i (rst_n),
        .clr_i   (clear_stats),
        .inc_i   (overrun),
        .count_o (overrun_count)
    );

    assign telemetry_request = req_q;
    assign locked            = locked_q;
    assign last_data         = last_q;

endmodule

// File: tb/tb_telemetry_test_checker.sv
// Directed bench: a 32-bit-stats checker plus a 4-bit-stats copy sharing the same stimulus.
module tb_telemetry_test_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear_stats;
    logic        trig;
    logic        valid;
    logic [31:0] data;

    logic        req, locked;
    logic [9:0]  last;
    logic [31:0] rx, err, to, ov;

    logic        req_s, locked_s;
    logic [9:0]  last_s;
    logic [3:0]  rx_s, err_s, to_s, ov_s;

    int n_checks = 0;
    int n_errors = 0;

    always #4 clk = ~clk;

    telemetry_test_checker #(.CNT_W(10), .TIMEOUT_CYCLES(16), .STAT_W(32)) dut (
        .clk_128MHz           (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .clear_stats          (clear_stats),
        .telemetry_trigger    (trig),
        .telemetry_request    (req),
        .telemetry_data       (data),
        .telemetry_data_valid (valid),
        .locked               (locked),
        .last_data            (last),
        .rx_count             (rx),
        .error_count          (err),
        .timeout_count        (to),
        .overrun_count        (ov)
    );

    telemetry_test_checker #(.CNT_W(10), .TIMEOUT_CYCLES(16), .STAT_W(4)) dut_s (
        .clk_128MHz           (clk),
        .rst_n                (rst_n),
        .enable               (enable),
        .clear_stats          (clear_stats),
        .telemetry_trigger    (trig),
        .telemetry_request    (req_s),
        .telemetry_data       (data),
        .telemetry_data_valid (valid),
        .locked               (locked_s),
        .last_data            (last_s),
        .rx_count             (rx_s),
        .error_count          (err_s),
        .timeout_count        (to_s),
        .overrun_count        (ov_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"},  {31'd0, req},    0);
        check_eq({tag, "_lock"}, {31'd0, locked}, 0);
        check_eq({tag, "_last"}, {22'd0, last},   0);
        check_eq({tag, "_rx"},   rx,  0);
        check_eq({tag, "_err"},  err, 0);
        check_eq({tag, "_to"},   to,  0);
        check_eq({tag, "_ov"},   ov,  0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 4 && req !== 1'b1; i++) @(negedge clk);
        check_eq("req_seen", {31'd0, req}, 1);
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear_stats = 1'b1;
        @(negedge clk) clear_stats = 1'b0;
    endtask

    // Source model: valid with the word in the first WAIT cycle, then a 3-cycle gap.
    task automatic send_word(input logic [31:0] w);
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        wait_req();
        @(negedge clk) begin valid = 1'b1; data = w; end
        @(negedge clk) valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; clear_stats = 1'b0;
        trig = 1'b0; valid = 1'b0; data = '0;

        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // 1: clean sequence 0..19; 4-bit copy saturates at 15
        for (int i = 0; i < 20; i++) send_word(32'(i));
        check_eq("t1_rx", rx, 20);
        check_eq("t1_err", err, 0);
        check_eq("t1_to", to, 0);
        check_eq("t1_lock", {31'd0, locked}, 1);
        check_eq("t1_last", {22'd0, last}, 19);
        check_eq("t1_rx_sat", {28'd0, rx_s}, 15);
        check_eq("t1_err_sat", {28'd0, err_s}, 0);

        // 2: dropped word 5
        pulse_clear();
        check_eq("t2_clr_rx", rx, 0);
        check_eq("t2_clr_lock", {31'd0, locked}, 0);
        send_word(32'd4);
        send_word(32'd6);
        send_word(32'd7);
        check_eq("t2_err", err, 1);
        check_eq("t2_rx", rx, 3);
        check_eq("t2_last", {22'd0, last}, 7);

        // 3: counter wrap 1020..1023,0,1 then 2
        pulse_clear();
        for (int i = 0; i < 6; i++) send_word(32'((1020 + i) % 1024));
        check_eq("t3_err_wrap", err, 0);
        check_eq("t3_last_wrap", {22'd0, last}, 1);
        send_word(32'd2);
        check_eq("t3_err_exp2", err, 0);
        check_eq("t3_rx", rx, 7);

        // 4: no valid -> timeout after 16 WAIT cycles
        pulse_clear();
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        check_eq("t4_req", {31'd0, req}, 1);
        repeat (16) @(negedge clk);
        check_eq("t4_to_early", to, 0);
        @(negedge clk);
        check_eq("t4_to", to, 1);
        check_eq("t4_rx", rx, 0);
        check_eq("t4_lock", {31'd0, locked}, 0);
        send_word(32'd9);
        check_eq("t4_rx_after", rx, 1);
        check_eq("t4_lock_after", {31'd0, locked}, 1);

        // 5: trigger during REQ and upper bit 12 set with correct low bits (expected 10)
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b1;
        check_eq("t5_req", {31'd0, req}, 1);
        @(negedge clk) begin trig = 1'b0; valid = 1'b1; data = 32'h0000_100A; end
        @(negedge clk) valid = 1'b0;
        check_eq("t5_ov", ov, 1);
        check_eq("t5_err", err, 1);
        check_eq("t5_last", {22'd0, last}, 10);
        check_eq("t5_rx", rx, 2);
        repeat (2) @(negedge clk);
        // valid in IDLE is ignored; trigger with enable low is ignored
        valid = 1'b1; data = 32'd55;
        repeat (2) @(negedge clk);
        valid = 1'b0;
        check_eq("t5_idle_valid_rx", rx, 2);
        check_eq("t5_idle_valid_last", {22'd0, last}, 10);
        enable = 1'b0; trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        check_eq("t5_dis_req", {31'd0, req}, 0);
        @(negedge clk);
        check_eq("t5_dis_ov", ov, 1);
        enable = 1'b1;

        // 6: async reset during WAIT
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("t6_post");
        send_word(32'd5);
        check_eq("t6_rx", rx, 1);
        check_eq("t6_lock", {31'd0, locked}, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
